// File: rtl/vga_frame_streamer_if.sv
`timescale 1ns/1ps
// Image-buffer read port and VGA pin bundle shared by the streamer and whatever
// drives the buffer / watches the monitor pins.
interface vga_frame_streamer_if #(parameter int ADDR_W = 16) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              hsync;
    logic              vsync;
    logic              vga_clk;
    logic              blank_n;
    logic              frame_start;

    modport master (
        output mem_addr,
        input  mem_data,
        output red, green, blue, hsync, vsync, vga_clk, blank_n, frame_start
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  red, green, blue, hsync, vsync, vga_clk, blank_n, frame_start
    );
endinterface

// File: rtl/vga_frame_streamer.sv
`timescale 1ns/1ps
// VGA raster generator that scans a grayscale image buffer, centres it on the
// visible area and only switches between black and image on frame boundaries.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   WAIT_FRAME | syncs running, RGB forced black (no valid image yet)
//   DISPLAY    | syncs running, image window shows buffer contents
module vga_frame_streamer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_ready,
    vga_frame_streamer_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X0      = (H_ACTIVE - IMG_W) / 2;
    localparam int Y0      = (V_ACTIVE - IMG_H) / 2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_X0 = HW'(X0);
    localparam logic [HW-1:0] IMG_X1 = HW'(X0 + IMG_W);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_Y0 = VW'(Y0);
    localparam logic [VW-1:0] IMG_Y1 = VW'(Y0 + IMG_H);

    typedef enum logic {WAIT_FRAME = 1'b0, DISPLAY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              phase, started;
    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic              s1_hs, s1_vs, s1_act, s1_img;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        pix_q;
    logic              hs_q, vs_q, blank_q, fs_q;
    logic              tick, h_wrap, v_wrap, at_origin, active, in_img, hs_win, vs_win;

    assign tick      = enable & phase;
    assign h_wrap    = (h == H_LAST);
    assign v_wrap    = (v == V_LAST);
    assign at_origin = (h == '0) && (v == '0);
    assign active    = (h < H_VIS) && (v < V_VIS);
    assign in_img    = active && (h >= IMG_X0) && (h < IMG_X1) && (v >= IMG_Y0) && (v < IMG_Y1);
    assign hs_win    = (h >= HS_BEG) && (h < HS_END);
    assign vs_win    = (v >= VS_BEG) && (v < VS_END);
    assign addr_nxt  = ADDR_W'((32'(v) - 32'(Y0)) * 32'(IMG_W) + (32'(h) - 32'(X0)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_FRAME;
        else        state <= state_nxt;
    end

    // frame_ready is only looked at when the raster sits on (0,0), so a frame is never torn
    always_comb begin
        state_nxt = state;
        if (!enable)
            state_nxt = WAIT_FRAME;
        else if (tick && at_origin)
            state_nxt = frame_ready ? DISPLAY : WAIT_FRAME;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   <= 1'b0;
            started <= 1'b0;
            h       <= '0;
            v       <= '0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_act  <= 1'b0;
            s1_img  <= 1'b0;
            addr_q  <= '0;
            pix_q   <= 8'h00;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else if (!enable) begin
            phase   <= 1'b0;
            started <= 1'b0;
            h       <= '0;
            v       <= '0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_act  <= 1'b0;
            s1_img  <= 1'b0;
            addr_q  <= '0;
            pix_q   <= 8'h00;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            phase <= ~phase;
            fs_q  <= 1'b0;
            if (tick) begin
                started <= 1'b1;
                fs_q    <= (h_wrap && v_wrap) || !started;
                if (h_wrap) begin
                    h <= '0;
                    v <= v_wrap ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
                // stage 1: address goes out now, data is back before the next tick
                s1_hs  <= ~hs_win;
                s1_vs  <= ~vs_win;
                s1_act <= active;
                s1_img <= in_img;
                if (in_img) addr_q <= addr_nxt;
                hs_q    <= s1_hs;
                vs_q    <= s1_vs;
                blank_q <= s1_act;
                pix_q   <= (s1_img && state == DISPLAY) ? bus.mem_data : 8'h00;
            end
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.red         = pix_q;
    assign bus.green       = pix_q;
    assign bus.blue        = pix_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.blank_n     = blank_q;
    assign bus.vga_clk     = phase;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_frame_streamer.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for vga_frame_streamer on a reduced raster so that
// several complete frames, enable drops and an async reset fit in a short run.
module tb_vga_frame_streamer;
    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int IW = 16, IH = 16, AW = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int X0 = (HA - IW) / 2;
    localparam int Y0 = (VA - IH) / 2;

    typedef struct packed { logic hs; logic vs; logic bn; logic [7:0] rgb; } pix_t;
    typedef enum int {K_RESET, K_IDLE, K_RUN, K_TICK} kind_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic frame_ready = 1'b0;

    vga_frame_streamer_if #(.ADDR_W(AW)) bus ();

    vga_frame_streamer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frame_ready(frame_ready),
        .bus(bus)
    );

    always #10 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    pix_t            exp_q[$];
    kind_t           kind = K_RESET;
    int              n_edge = 0;
    int              cur_n = 0;
    int              cur_k = 0;
    bit              disp = 1'b0;
    logic [AW-1:0]   exp_addr = '0;

    function automatic pix_t idle_pix();
        pix_t p;
        p.hs = 1'b1; p.vs = 1'b1; p.bn = 1'b0; p.rgb = 8'h00;
        return p;
    endfunction

    task automatic restart(input kind_t kd);
        exp_q.delete();
        exp_q.push_back(idle_pix());
        n_edge   = 0;
        disp     = 1'b0;
        exp_addr = '0;
        kind     = kd;
    endtask

    // pixel k of the run: raster position straight from the tick index
    task automatic model_pixel(input int k);
        int h, v, a;
        pix_t p;
        bit img;
        h = k % HT;
        v = (k / HT) % VT;
        if (k % FT == 0) disp = frame_ready;
        p.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        p.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        p.bn  = (h < HA) && (v < VA);
        img   = p.bn && h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH;
        a     = ((v - Y0) * IW + (h - X0)) % (1 << AW);
        p.rgb = 8'h00;
        if (img) begin
            exp_addr = AW'(a);
            if (disp) p.rgb = mem[AW'(a)];
        end
        exp_q.push_back(p);
    endtask

    initial begin
        restart(K_RESET);
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) restart(K_RESET);
            else if (!enable) restart(K_IDLE);
            else begin
                cur_n = n_edge;
                n_edge++;
                if (cur_n % 2 == 1) begin
                    cur_k = cur_n / 2;
                    kind  = K_TICK;
                    model_pixel(cur_k);
                end else begin
                    kind = K_RUN;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   hs_fall = -1, vs_fall = -1, fs_last = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (kind == K_RESET || kind == K_IDLE) begin
                chk("idle_hsync", bus.hsync, 1);
                chk("idle_vsync", bus.vsync, 1);
                chk("idle_blank_n", bus.blank_n, 0);
                chk("idle_rgb", {bus.red, bus.green, bus.blue}, 0);
                chk("idle_frame_start", bus.frame_start, 0);
                chk("idle_vga_clk", bus.vga_clk, 0);
                if (kind == K_RESET) chk("reset_mem_addr", bus.mem_addr, 0);
                hs_fall = -1; vs_fall = -1; fs_last = -1;
            end else begin
                chk("vga_clk", bus.vga_clk, int'(cur_n % 2 == 0));
                if (kind == K_TICK) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("hsync", bus.hsync, e.hs);
                        chk("vsync", bus.vsync, e.vs);
                        chk("blank_n", bus.blank_n, e.bn);
                        chk("red", bus.red, e.rgb);
                        chk("green", bus.green, e.rgb);
                        chk("blue", bus.blue, e.rgb);
                    end
                    chk("mem_addr", bus.mem_addr, exp_addr);
                    chk("frame_start", bus.frame_start, int'(cur_k == 0 || cur_k % FT == FT - 1));
                end else begin
                    chk("frame_start_width", bus.frame_start, 0);
                end
                if (hs_prev && !bus.hsync) begin
                    if (hs_fall >= 0) chk("line_period_clk", cyc - hs_fall, 2 * HT);
                    else chk("first_hsync_fall_edge", cur_n, 2 * (HA + HFP) + 3);
                    hs_fall = cyc;
                end
                if (!hs_prev && bus.hsync && hs_fall >= 0) chk("hsync_low_clk", cyc - hs_fall, 2 * HS);
                if (vs_prev && !bus.vsync) begin
                    if (vs_fall >= 0) chk("vsync_period_clk", cyc - vs_fall, 2 * FT);
                    vs_fall = cyc;
                end
                if (!vs_prev && bus.vsync && vs_fall >= 0) chk("vsync_low_clk", cyc - vs_fall, 2 * VS * HT);
                if (bus.frame_start) begin
                    if (fs_last >= 0) chk("frame_start_period_clk", cyc - fs_last, 2 * FT);
                    if (cur_k != 0) fs_last = cyc;
                end
            end
            hs_prev = bus.hsync;
            vs_prev = bus.vsync;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
        reset = 1'b0; enable = 1'b0; frame_ready = 1'b0;
        run(3);
        reset = 1'b1;
        run(1);
        enable = 1'b1;

        run(9000);
        run($urandom_range(2000, 6000));
        frame_ready = 1'b1;
        run(9000);

        for (int i = 0; i < 4; i++) begin
            run($urandom_range(1000, 7000));
            frame_ready = ~frame_ready;
        end

        for (int i = 0; i < 2; i++) begin
            run($urandom_range(200, 3000));
            enable = 1'b0;
            run($urandom_range(2, 30));
            enable = 1'b1;
        end
        run(3000);

        w = 0;
        while (bus.hsync !== 1'b0 && w < 4 * HT) begin
            @(negedge clk);
            w++;
        end
        chk("hsync_low_before_async_reset", bus.hsync, 0);
        #3 reset = 1'b0;
        #1;
        chk("async_hsync", bus.hsync, 1);
        chk("async_vsync", bus.vsync, 1);
        chk("async_rgb", {bus.red, bus.green, bus.blue}, 0);
        chk("async_mem_addr", bus.mem_addr, 0);
        chk("async_vga_clk", bus.vga_clk, 0);
        run(2);
        reset = 1'b1;
        run(2 * FT + 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_streamer.md
Name: vga_frame_streamer

Overview:
- Downstream display stage of the processor top: scans the image buffer the processor writes and drives the 8-bit R/G/B, hsync and vsync pins of a 640x480@60 VGA monitor.
- Generates raster timing from the 50 MHz system clock using a /2 pixel enable, giving a 25 MHz pixel rate.
- Fetches one 8-bit grayscale pixel per pixel tick from a synchronous-read buffer and centres the image on screen.
- Starts showing a new image only on a frame boundary after the processor asserts its finished flag.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 16, buffer address width

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- enable  in  1  display enable; 0 = timing halted
- frame_ready  in  1  processor finished; image buffer is valid
- mem_addr  out  ADDR_W  buffer read address
- mem_data  in  8  buffer read data; valid 1 clk after mem_addr
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vga_clk  out  1  pixel clock to the DAC
- blank_n  out  1  0 during blanking
- frame_start  out  1  one-clk pulse when h=0, v=0 is entered

Behaviour:
- Reset (reset=0, async):
  - counters h=0, v=0; tick phase=0; state=WAIT_FRAME
  - red/green/blue=0; hsync=1; vsync=1; blank_n=0; vga_clk=0; mem_addr=0; frame_start=0
- Pixel tick:
  - phase toggles every clk while enable=1; tick occurs when phase=1, i.e. every 2nd clk.
  - vga_clk = phase, so the rising edge lands mid-pixel.
- Counters:
  - h advances on each tick, range 0..799 (H total 800).
  - At h=799: h wraps to 0 and v increments, range 0..524 (V total 525).
  - At h=799 and v=524: both wrap to 0.
- Sync windows, computed from raw counters:
  - hsync is low for 656<=h<752.
  - vsync is low for 490<=v<492.
  - active region is h<640 and v<480.
- Image window:
  - X0 = (H_ACTIVE-IMG_W)/2 = 192; Y0 = (V_ACTIVE-IMG_H)/2 = 112.
  - in_img = active and X0<=h<X0+IMG_W and Y0<=v<Y0+IMG_H.
  - mem_addr = (v-Y0)*IMG_W + (h-X0), truncated to ADDR_W; updated on the tick when in_img=1, held otherwise.
- Pipeline (2 ticks, registered outputs):
  - Tick N: issue mem_addr; capture sync, active and in_img into stage-1 registers.
  - mem_data returns by the next clk.
  - Tick N+1: register outputs.
    - hsync, vsync and blank_n come from stage 1.
    - RGB = mem_data replicated to all three channels if stage-1 in_img=1 and state=DISPLAY; otherwise RGB=0.
  - Every output is therefore delayed 2 ticks (4 clk) from its counter position, and syncs and RGB stay mutually aligned.
- FSM:
  - WAIT_FRAME -> DISPLAY on the tick where h=0, v=0, if frame_ready=1.
  - DISPLAY -> WAIT_FRAME on the tick where h=0, v=0, if frame_ready=0. A frame is never torn mid-scan.
  - Syncs run in both states; WAIT_FRAME outputs black.
- frame_start: pulses for 1 clk on the tick where the counters wrap to (0,0), and on the first tick after enable rises.
- enable=0:
  - counters, phase and pipeline are synchronously cleared to their reset values.
  - hsync=vsync=1, RGB=0, state=WAIT_FRAME.
  - Restart from h=0, v=0 when enable returns to 1.
- Simultaneous events: enable=0 dominates frame_ready. frame_ready is sampled only at the frame boundary.
- Reset mid-frame: all outputs return to reset values immediately; no residual sync pulse.

Test Plan:
- Reset held 50 ns, then enable=1 -> first tick at clk 2; hsync falls 4 clk after h=656 and is low for 192 clk; line period is exactly 1600 clk.
- Free-run one frame -> vsync low for 2 lines (3200 clk) starting at line 490 (+4 clk pipeline); frame period 840000 clk; frame_start pulses once per frame.
- frame_ready=1, buffer mem[a]=a[7:0] -> at (h=192, v=112) mem_addr=0 and RGB=0x00 two ticks later; at (h=200, v=113) mem_addr=264 and RGB=0x08; at (h=448, v=112) RGB=0 (outside window).
- frame_ready rises mid-frame at v=300 -> RGB stays 0 until the next (0,0); the following frame shows the image. frame_ready falls mid-frame -> the current frame completes, then black.
- enable dropped at h=400, v=200 -> next clk hsync=vsync=1, RGB=0; re-enable -> frame_start pulse and counting resumes from (0,0).
- Async reset asserted between clk edges during hsync low -> hsync=1, RGB=0, mem_addr=0 immediately, without waiting for clk.
